// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, response error codes,
// FSM states and the alignment rule used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } state_e;

  // An access that cannot go to the bus: illegal size or not naturally aligned.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication across lanes
// and load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = 4'b0011 << addr_lo;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

  // Each lane carries the low byte, the matching half-word byte, or its own byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] = (size == SIZE_BYTE) ? wdata[7:0] :
                                  (size == SIZE_HALF) ? wdata[8*(gi%2) +: 8] :
                                                        wdata[8*gi +: 8];
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (size)
      SIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SIZE_WORD: load_data = shifted;
      default:   load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage access at a time, runs it on a
// request/grant/rvalid bus with a cycle timeout and returns a one-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_rd_o,
  output logic [1:0]  rsp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state_reg;
  logic [CW-1:0] cnt_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic [1:0]  addr_lo_reg;
  logic        uns_reg;
  logic [4:0]  rd_reg;

  logic [1:0]  align_size;
  logic [1:0]  align_addr_lo;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] load_data;
  logic        timeout_hit;

  // In IDLE the aligner shapes the incoming request; afterwards it decodes the latched one.
  assign align_size    = (state_reg == IDLE) ? req_size_i        : size_reg;
  assign align_addr_lo = (state_reg == IDLE) ? req_addr_i[1:0]   : addr_lo_reg;
  // The counter keeps running across the grant, so it may sit at TIMEOUT in WAIT.
  assign timeout_hit   = (cnt_reg >= CW'(TIMEOUT - 1));

  lsu_align u_align (
    .size        (align_size),
    .addr_lo     (align_addr_lo),
    .is_unsigned (uns_reg),
    .wdata       (req_wdata_i),
    .rdata       (mem_rdata_i),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      size_reg    <= 2'b00;
      addr_lo_reg <= 2'b00;
      uns_reg     <= 1'b0;
      rd_reg      <= 5'd0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_rd_o    <= 5'd0;
      rsp_err_o   <= ERR_NONE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_be_o    <= 4'h0;
      mem_wdata_o <= 32'h0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_rd_o    <= 5'd0;
      rsp_err_o   <= ERR_NONE;
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            we_reg      <= req_we_i;
            size_reg    <= req_size_i;
            addr_lo_reg <= req_addr_i[1:0];
            uns_reg     <= req_unsigned_i;
            rd_reg      <= req_rd_i;
            cnt_reg     <= '0;
            req_ready_o <= 1'b0;
            if (access_bad(req_size_i, req_addr_i[1:0])) begin
              state_reg   <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= ERR_MISALIGN;
              rsp_rd_o    <= req_we_i ? 5'd0 : req_rd_i;
            end else begin
              state_reg   <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= {req_addr_i[31:2], 2'b00};
              mem_be_o    <= be;
              mem_wdata_o <= wdata_rep;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            cnt_reg   <= cnt_reg + CW'(1);
            if (we_reg) begin
              state_reg   <= RESP;
              rsp_valid_o <= 1'b1;
            end else begin
              state_reg <= WAIT;
            end
          end else if (timeout_hit) begin
            mem_req_o   <= 1'b0;
            state_reg   <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= ERR_TIMEOUT;
            rsp_rd_o    <= we_reg ? 5'd0 : rd_reg;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_reg   <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= load_data;
            rsp_rd_o    <= rd_reg;
          end else if (timeout_hit) begin
            state_reg   <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= ERR_TIMEOUT;
            rsp_rd_o    <= rd_reg;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// checked cycle by cycle against a byte-level reference model.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic [4:0]  req_rd_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic [1:0]  rsp_err_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_rd_i(req_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o),
    .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed bytes out of the bus word, then extend.
  function automatic logic [31:0] load_model(input logic [31:0] word, input int lo,
                                             input int nbytes, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nbytes; i++) v[8*i +: 8] = word[8*(lo+i) +: 8];
    if (!uns && v[8*nbytes-1])
      for (int i = nbytes; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
    chk({tag, "_rsp_rd"}, rsp_rd_o, 0);
    chk({tag, "_rsp_err"}, rsp_err_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_be"}, mem_be_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
  endtask

  // One complete access, entered and left at a negedge with the LSU idle.
  // gd: cycles of grant delay in REQ; rvd: cycles between grant and rvalid.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd,
                           input int gd, input int rvd, input logic [31:0] rdata,
                           output logic [31:0] got_rdata, output int got_lat);
    int n, lo, g, g_eff, r, deadline, rcyc;
    logic bad;
    logic [1:0]  e_err;
    logic [31:0] e_data, e_wrep;
    logic [3:0]  e_be;

    lo  = int'(addr[1:0]);
    n   = (size == 2'b11) ? 0 : (1 << size);
    bad = (n == 0) || ((lo % n) != 0);
    g   = 1 + gd;
    r   = g + 1 + rvd;
    deadline = (TO > g + 1) ? TO : g + 1;
    g_eff = (g <= TO) ? g : TO;
    e_data = 32'h0;
    if (bad) begin
      rcyc = 1; e_err = 2'b01;
    end else if (g > TO) begin
      rcyc = TO + 1; e_err = 2'b10;
    end else if (we) begin
      rcyc = g + 1; e_err = 2'b00;
    end else if (r <= deadline) begin
      rcyc = r + 1; e_err = 2'b00; e_data = load_model(rdata, lo, n, uns);
    end else begin
      rcyc = deadline + 1; e_err = 2'b10;
    end
    e_be = 4'b0000;
    for (int i = 0; i < n; i++) e_be[lo+i] = 1'b1;
    case (n)
      1:       e_wrep = {4{wdata[7:0]}};
      2:       e_wrep = {2{wdata[15:0]}};
      default: e_wrep = wdata;
    endcase
    got_rdata = 32'hDEAD_BEEF;
    got_lat   = -1;

    chk("idle_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_size_i = size; req_unsigned_i = uns; req_rd_i = rd;
    @(negedge clk);
    for (int c = 1; c <= rcyc; c++) begin
      chk("busy_ready", req_ready_o, 0);
      chk("mem_req", mem_req_o, (!bad && c <= g_eff) ? 1 : 0);
      chk("rsp_valid", rsp_valid_o, (c == rcyc) ? 1 : 0);
      if (rsp_valid_o && got_lat < 0) got_lat = c;
      if (c == 1 && !bad) begin
        chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("mem_be", mem_be_o, e_be);
        chk("mem_we", mem_we_o, we);
        if (we) chk("mem_wdata", mem_wdata_o, e_wrep);
      end
      if (c == rcyc) begin
        chk("rsp_err", rsp_err_o, e_err);
        chk("rsp_rd", rsp_rd_o, we ? 5'd0 : rd);
        chk("rsp_rdata", rsp_rdata_o, e_data);
        got_rdata = rsp_rdata_o;
      end
      // Requests presented while busy must be ignored; rvalid noise before WAIT too.
      req_valid_i = (c < rcyc) ? 1'($urandom) : 1'b0;
      req_we_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
      req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom); req_rd_i = 5'($urandom);
      mem_gnt_i    = (!bad && c == g && g <= TO);
      mem_rvalid_i = (!bad && !we && c == r && r <= deadline) ? 1'b1 :
                     (c <= g) ? 1'($urandom) : 1'b0;
      mem_rdata_i  = (mem_rvalid_i && c == r) ? rdata : $urandom;
      @(negedge clk);
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("after_ready", req_ready_o, 1);
    chk("after_rsp_valid", rsp_valid_o, 0);
    chk("after_mem_req", mem_req_o, 0);
    $display("access we=%0d addr=%h size=%0d uns=%0d rd=%0d gd=%0d rvd=%0d -> err=%0d rdata=%h lat=%0d",
             we, addr, size, uns, rd, gd, rvd, e_err, got_rdata, got_lat);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    rst = 1'b1;
    req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; req_size_i = 0;
    req_unsigned_i = 0; req_rd_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Load byte, signed, from the top lane.
    do_access(1'b0, 32'h0000_1003, 32'h0, 2'b00, 1'b0, 5'd7, 0, 0, 32'h80FF_FF00, d, lat);
    chk("lb_data", d, 32'hFFFF_FF80);
    chk("lb_latency", lat, 3);
    // Load half, unsigned, upper half.
    do_access(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b1, 5'd9, 0, 0, 32'hBEEF_1234, d, lat);
    chk("lhu_data", d, 32'h0000_BEEF);
    // Store half.
    do_access(1'b1, 32'h0000_0010, 32'h0000_ABCD, 2'b01, 1'b0, 5'd3, 0, 0, 32'h0, d, lat);
    chk("sh_latency", lat, 2);
    // Misaligned word load.
    do_access(1'b0, 32'h0000_0006, 32'h0, 2'b10, 1'b0, 5'd4, 0, 0, 32'h0, d, lat);
    chk("mis_latency", lat, 1);
    // Grant withheld past TIMEOUT.
    do_access(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 5'd5, 20, 0, 32'h0, d, lat);
    chk("to_latency", lat, TO + 1);
    // Illegal size, and a load whose rvalid never arrives in time.
    do_access(1'b1, 32'h0000_0200, 32'h1234_5678, 2'b11, 1'b0, 5'd6, 0, 0, 32'h0, d, lat);
    do_access(1'b0, 32'h0000_0204, 32'h0, 2'b10, 1'b0, 5'd8, 1, 9, 32'h5555_AAAA, d, lat);

    // Reset while waiting for read data, with a late rvalid afterwards.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h40; req_size_i = 2'b10; req_rd_i = 5'd12;
    @(negedge clk);
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check_reset_outputs("rst_late_rvalid");
    @(negedge clk);
    chk("rst_no_rsp", rsp_valid_o, 0);
    $display("reset-in-WAIT sequence done");

    // Randomized accesses, biased toward aligned legal ones.
    for (int t = 0; t < 80; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_access(1'($urandom), a, $urandom, sz, 1'($urandom), 5'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom, d, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for mem_gnt_i or mem_rvalid_i before abort.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  execute-stage access request.
- req_ready_o  out  1  LSU can accept.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, LSB-justified.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend load.
- req_rd_i  in  5  load destination register.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  extended load data.
- rsp_rd_o  out  5  destination register.
- rsp_err_o  out  2  00 ok, 01 misaligned, 10 timeout.
- mem_req_o  out  1  bus request.
- mem_gnt_i  in  1  bus grant.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  32  word-aligned address, bits[1:0] = 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-004 SHALL register all req_* fields on req_valid_i && req_ready_o; request is ignored in all other states.
REQ-005 SHALL transition from IDLE on accept:
- misaligned or size 11: go to RESP, err 01, no bus access.
- otherwise: go to REQ.
- Misaligned = half with addr[0] = 1, or word with addr[1:0] != 0.
REQ-006 SHALL drive in REQ:
- mem_req_o = 1; mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o stable until grant.
- On mem_gnt_i: store goes to RESP, load goes to WAIT.
REQ-007 SHALL go from WAIT to RESP on mem_rvalid_i, capturing the extracted load data; mem_rvalid_i is ignored outside WAIT.
REQ-008 SHALL assert in RESP for exactly one cycle:
- rsp_valid_o = 1, rsp_rd_o = latched rd (0 for stores), rsp_rdata_o = load data (0 for stores and errors).
- Then return to IDLE.
REQ-009 SHALL form byte enables as: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111.
REQ-010 SHALL form mem_wdata_o as: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-011 SHALL form load data as mem_rdata_i >> (8*addr[1:0]), truncated to size, then sign-extended, or zero-extended when req_unsigned_i = 1.
REQ-012 SHALL count cycles spent in REQ plus WAIT; when the count reaches TIMEOUT, go to RESP with err 10 and deassert mem_req_o.
REQ-013 SHALL reset the counter on each accept.
REQ-014 SHALL give load latency accept→rsp_valid_o = 3 cycles with zero-wait grant and rvalid one cycle after grant.
REQ-015 SHALL give store latency accept→rsp_valid_o = 2 cycles with zero-wait grant.
REQ-016 SHALL not drive rsp_valid_o and req_ready_o high in the same cycle; the next accept is possible the cycle after RESP.

Reset
REQ-017 SHALL, with rst high at a clock edge, force:
- state IDLE, counter 0.
- req_ready_o 1 after the edge.
- rsp_valid_o 0, rsp_rdata_o 0, rsp_rd_o 0, rsp_err_o 00.
- mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_be_o 0, mem_wdata_o 0.
REQ-018 SHALL abandon any in-flight access on reset mid-operation with no response, and ignore a late mem_rvalid_i after reset.

Structure
REQ-019 SHALL place size encodings, err codes and the state enum in shared package lsu_pkg.
REQ-020 SHALL place byte-enable, store replication and load extract/extend logic in combinational sub-module lsu_align; FSM, registers and timeout stay in lsu.

Verification
REQ-021 SHALL cover these directed scenarios:
- Load byte, addr 0x1003, signed, rdata 0x80FF_FF00 → mem_addr 0x1000, be 1000, rsp_rdata 0xFFFF_FF80, err 00, rsp_valid at accept+3.
- Load half, addr 0x2002, unsigned, rdata 0xBEEF_1234 → be 1100, rsp_rdata 0x0000_BEEF.
- Store half, wdata 0x0000_ABCD, addr 0x10 → mem_wdata 0xABCD_ABCD, be 0011, mem_we 1, rsp_valid at accept+2, rsp_rd 0.
- Load word, addr 0x6 → no mem_req_o, rsp_err 01 at accept+1, rdata 0.
- Grant withheld, TIMEOUT = 4 → mem_req_o high 4 cycles then drops, rsp_err 10.
- rst asserted in WAIT, rvalid arrives next cycle → no rsp_valid, req_ready_o 1, all outputs at reset values.
